// File: rtl/uart_frame_parser.sv
// Command framer behind the UART receiver: turns done-level bytes into
// SYNC/CMD/ARG/CHK frames, checks the XOR checksum and an inter-byte timeout.
module uart_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rx_done,
    input  logic [7:0] uart_rx_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       frame_err,
    output logic [1:0] err_type,
    output logic [7:0] err_cnt,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_CMD = 2'd1,
        GET_ARG = 2'd2,
        GET_CHK = 2'd3
    } state_t;

    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYC - 1);

    state_t      state, state_nxt;
    logic        done_d;
    logic        byte_stb;
    logic [23:0] to_cnt, to_cnt_nxt;
    logic [7:0]  cmd_q, cmd_q_nxt;
    logic [7:0]  arg_q, arg_q_nxt;
    logic [7:0]  cmd_code_nxt, cmd_arg_nxt, err_cnt_nxt;
    logic [1:0]  err_type_nxt;
    logic        cmd_valid_nxt, frame_err_nxt;
    logic        raise_err;

    // The receiver holds done high for a whole bit-time; only its rising edge is a byte.
    assign byte_stb  = uart_rx_done & ~done_d;
    assign dbg_state = state;

    always_comb begin
        state_nxt     = state;
        to_cnt_nxt    = to_cnt + 24'd1;
        cmd_q_nxt     = cmd_q;
        arg_q_nxt     = arg_q;
        cmd_code_nxt  = cmd_code;
        cmd_arg_nxt   = cmd_arg;
        cmd_valid_nxt = 1'b0;
        frame_err_nxt = 1'b0;
        err_type_nxt  = err_type;
        err_cnt_nxt   = err_cnt;
        raise_err     = 1'b0;

        case (state)
            IDLE: begin
                to_cnt_nxt = '0;
                if (byte_stb && uart_rx_data == SYNC_BYTE) begin
                    state_nxt = GET_CMD;
                end
            end
            GET_CMD: begin
                if (byte_stb) begin
                    cmd_q_nxt = uart_rx_data;
                    state_nxt = GET_ARG;
                end
            end
            GET_ARG: begin
                if (byte_stb) begin
                    arg_q_nxt = uart_rx_data;
                    state_nxt = GET_CHK;
                end
            end
            GET_CHK: begin
                if (byte_stb) begin
                    state_nxt = IDLE;
                    if (uart_rx_data == (cmd_q ^ arg_q)) begin
                        cmd_code_nxt  = cmd_q;
                        cmd_arg_nxt   = arg_q;
                        cmd_valid_nxt = 1'b1;
                    end else begin
                        raise_err    = 1'b1;
                        err_type_nxt = 2'b01;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A strobe landing on the expiry cycle keeps the frame alive.
        if (state != IDLE) begin
            if (byte_stb) begin
                to_cnt_nxt = '0;
            end else if (to_cnt == TO_LAST) begin
                state_nxt    = IDLE;
                to_cnt_nxt   = '0;
                raise_err    = 1'b1;
                err_type_nxt = 2'b10;
            end
        end

        if (raise_err) begin
            frame_err_nxt = 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt_nxt = err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            done_d    <= 1'b0;
            to_cnt    <= '0;
            cmd_q     <= '0;
            arg_q     <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_arg   <= '0;
            frame_err <= 1'b0;
            err_type  <= '0;
            err_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_d    <= uart_rx_done;
            to_cnt    <= to_cnt_nxt;
            cmd_q     <= cmd_q_nxt;
            arg_q     <= arg_q_nxt;
            cmd_valid <= cmd_valid_nxt;
            cmd_code  <= cmd_code_nxt;
            cmd_arg   <= cmd_arg_nxt;
            frame_err <= frame_err_nxt;
            err_type  <= err_type_nxt;
            err_cnt   <= err_cnt_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule
